// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// PC step, default vectors and the word-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [1:0]  ALIGN_MASK           = 2'b00;

  // Force the low two address bits to the word-aligned pattern.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & {30'h3FFF_FFFF, ALIGN_MASK};
  endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Single-entry holding register that presents one fetched instruction and
// its address to decode until it is consumed or squashed.
module fetch_hold_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Clearing only drops valid; the payload stays put until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_pc    <= 32'd0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one imem request at a time and
// hands instructions to decode. FETCH_MISALIGN_CHK_EN adds misalign_fault.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        trap_valid,
  output logic [31:0] pc_current
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_fault
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pcReq;

  logic         w_reqFire;
  logic         w_event;
  logic [31:0]  w_target;
  logic         w_load;
  logic         w_clear;

  assign w_event = trap_valid | redirect_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  logic w_misalign;
  logic r_misalignFault;

  // A misaligned redirect is converted into trap entry.
  assign w_misalign = redirect_valid & ~trap_valid & (redirect_addr[1:0] != ALIGN_MASK);
  assign w_target   = (trap_valid | w_misalign) ? TRAP_VECTOR : align_word(redirect_addr);

  always_ff @(posedge clk) begin
    if (rst) r_misalignFault <= 1'b0;
    else     r_misalignFault <= w_misalign;
  end

  assign misalign_fault = r_misalignFault;
`else
  assign w_target = trap_valid ? TRAP_VECTOR : align_word(redirect_addr);
`endif

  assign imem_req_valid = (r_state == REQ) & ~rst;
  assign imem_req_addr  = r_pc;
  assign pc_current     = r_pc;
  assign w_reqFire      = imem_req_valid & imem_req_ready;

  assign w_load  = (r_state == WAIT) & imem_rsp_valid & ~w_event;
  assign w_clear = (r_state == HOLD) & (if_ready | w_event);

  // A control-flow event always overrides the sequential pc update; requests
  // already accepted when it arrives are drained and their data discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_VECTOR;
      r_pcReq <= RESET_VECTOR;
    end else begin
      case (r_state)
        REQ: begin
          if (w_event) begin
            r_pc <= w_target;
            if (w_reqFire) r_state <= DRAIN;
          end else if (w_reqFire) begin
            r_pcReq <= r_pc;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_event) begin
            r_pc    <= w_target;
            r_state <= imem_rsp_valid ? REQ : DRAIN;
          end else if (imem_rsp_valid) begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_event) begin
            r_pc    <= w_target;
            r_state <= REQ;
          end else if (if_ready) begin
            r_pc    <= r_pc + PC_STEP;
            r_state <= REQ;
          end
        end
        DRAIN: begin
          if (w_event)        r_pc    <= w_target;
          if (imem_rsp_valid) r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase
    end
  end

  fetch_hold_reg u_holdReg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_instr (imem_rsp_data),
    .i_pc    (r_pcReq),
    .o_valid (if_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: imem responder with programmable
// latency plus a scoreboard of instructions expected at the decode handshake.
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReqValid;
  logic        reqReady = 1'b0;
  logic [31:0] imemReqAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        ifValid;
  logic        ifReady = 1'b0;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectAddr = 32'd0;
  logic        trapValid = 1'b0;
  logic [31:0] pcCurrent;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalignFault;
`endif

  int   assertCount = 0;
  int   failCount   = 0;
  int   rspLatency  = 1;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imemReqValid),
    .imem_req_ready (reqReady),
    .imem_req_addr  (imemReqAddr),
    .imem_rsp_valid (imemRspValid),
    .imem_rsp_data  (imemRspData),
    .if_valid       (ifValid),
    .if_ready       (ifReady),
    .if_instr       (ifInstr),
    .if_pc          (ifPc),
    .redirect_valid (redirectValid),
    .redirect_addr  (redirectAddr),
    .trap_valid     (trapValid),
    .pc_current     (pcCurrent)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_fault (misalignFault)
`endif
  );

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // imem model: one outstanding request, response rspLatency cycles after acceptance
  initial begin : responder
    logic        pending;
    logic [31:0] pendAddr;
    int          cnt;
    pending = 1'b0; pendAddr = 32'd0; cnt = 0;
    imemRspValid = 1'b0; imemRspData = 32'd0;
    forever begin
      @(negedge clk);
      imemRspValid = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          imemRspValid = 1'b1;
          imemRspData  = memData(pendAddr);
          pending      = 1'b0;
        end
      end
      #2;
      if (rst) pending = 1'b0;
      else if (imemReqValid && reqReady) begin
        pending  = 1'b1;
        pendAddr = imemReqAddr;
        cnt      = rspLatency;
      end
    end
  end

  // Decode-side scoreboard check on every accepted instruction
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ifValid && ifReady) begin
        if (sbq.size() == 0) begin
          assertCount++; failCount++;
          $display("[TB] FAIL unexpected_instr: got pc=%h instr=%h, required none", ifPc, ifInstr);
        end else begin
          e = sbq.pop_front();
          assertCount++;
          if (ifPc !== e.pc) begin
            failCount++;
            $display("[TB] FAIL sb_if_pc: got %h, required %h", ifPc, e.pc);
          end
          assertCount++;
          if (ifInstr !== e.instr) begin
            failCount++;
            $display("[TB] FAIL sb_if_instr: got %h, required %h", ifInstr, e.instr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitIfValid(input int maxCycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      @(negedge clk);
      #2;
      if (ifValid) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    assertCount++; if (imemReqValid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_req_valid: got %b, required 0", imemReqValid); end
    assertCount++; if (ifValid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_if_valid: got %b, required 0", ifValid); end
    assertCount++; if (ifInstr !== 32'd0) begin failCount++; $display("[TB] FAIL rst_if_instr: got %h, required 0", ifInstr); end
    assertCount++; if (ifPc !== 32'd0) begin failCount++; $display("[TB] FAIL rst_if_pc: got %h, required 0", ifPc); end
    assertCount++; if (pcCurrent !== 32'd0) begin failCount++; $display("[TB] FAIL rst_pc: got %h, required 0", pcCurrent); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    assertCount++; if (imemReqValid !== 1'b1) begin failCount++; $display("[TB] FAIL post_rst_req_valid: got %b, required 1", imemReqValid); end
    assertCount++; if (imemReqAddr !== 32'd0) begin failCount++; $display("[TB] FAIL post_rst_req_addr: got %h, required 0", imemReqAddr); end
  endtask

  task automatic test_sequential();
    int hsIdx[$];
    int got;
    @(negedge clk);
    rspLatency = 1; reqReady = 1'b1; ifReady = 1'b1;
    for (int k = 0; k < 4; k++) sbq.push_back('{pc: 32'(4 * k), instr: memData(32'(4 * k))});
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      if (imemReqValid && reqReady) hsIdx.push_back(i);
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < hsIdx.size()) ? hsIdx[k] : -1;
      assertCount++;
      if (got != 3 * k) begin failCount++; $display("[TB] FAIL seq_req_cycle%0d: got %0d, required %0d", k, got, 3 * k); end
    end
  endtask

  task automatic test_hold_stall();
    bit found;
    @(negedge clk);
    ifReady = 1'b0;
    sbq.push_back('{pc: 32'h10, instr: memData(32'h10)});
    waitIfValid(10, found);
    assertCount++;
    if (!found) begin failCount++; $display("[TB] FAIL stall_reach_hold: got no if_valid, required if_valid"); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); #2; end
      assertCount++; if (ifValid !== 1'b1) begin failCount++; $display("[TB] FAIL stall_if_valid%0d: got %b, required 1", c, ifValid); end
      assertCount++; if (ifPc !== 32'h10) begin failCount++; $display("[TB] FAIL stall_if_pc%0d: got %h, required 10", c, ifPc); end
      assertCount++; if (ifInstr !== memData(32'h10)) begin failCount++; $display("[TB] FAIL stall_if_instr%0d: got %h, required %h", c, ifInstr, memData(32'h10)); end
      assertCount++; if (imemReqValid !== 1'b0) begin failCount++; $display("[TB] FAIL stall_req_valid%0d: got %b, required 0", c, imemReqValid); end
    end
    @(negedge clk);
    ifReady = 1'b1;
    @(negedge clk);
    ifReady = 1'b0; reqReady = 1'b0;
    #2;
    assertCount++; if (imemReqValid !== 1'b1) begin failCount++; $display("[TB] FAIL release_req_valid: got %b, required 1", imemReqValid); end
    assertCount++; if (imemReqAddr !== 32'h14) begin failCount++; $display("[TB] FAIL release_req_addr: got %h, required 14", imemReqAddr); end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    rspLatency = 3; reqReady = 1'b1; ifReady = 1'b1;
    @(negedge clk);
    reqReady = 1'b0; redirectValid = 1'b1; redirectAddr = 32'h200;
    @(negedge clk);
    redirectValid = 1'b0;
    #2;
    assertCount++; if (imemReqValid !== 1'b0) begin failCount++; $display("[TB] FAIL drain_req_valid: got %b, required 0", imemReqValid); end
    assertCount++; if (pcCurrent !== 32'h200) begin failCount++; $display("[TB] FAIL drain_pc: got %h, required 200", pcCurrent); end
    @(negedge clk);
    #2;
    assertCount++; if (imemRspValid !== 1'b1) begin failCount++; $display("[TB] FAIL drain_rsp_seen: got %b, required 1", imemRspValid); end
    @(negedge clk);
    #2;
    assertCount++; if (ifValid !== 1'b0) begin failCount++; $display("[TB] FAIL stale_if_valid: got %b, required 0", ifValid); end
    assertCount++; if (imemReqValid !== 1'b1) begin failCount++; $display("[TB] FAIL redir_req_valid: got %b, required 1", imemReqValid); end
    assertCount++; if (imemReqAddr !== 32'h200) begin failCount++; $display("[TB] FAIL redir_req_addr: got %h, required 200", imemReqAddr); end
  endtask

  task automatic test_trap_hold();
    bit found;
    @(negedge clk);
    rspLatency = 1; reqReady = 1'b1; ifReady = 1'b0;
    waitIfValid(10, found);
    assertCount++;
    if (!found || ifPc !== 32'h200) begin failCount++; $display("[TB] FAIL trap_hold_pc: got %h (valid %b), required 200", ifPc, found); end
    trapValid = 1'b1; redirectValid = 1'b1; redirectAddr = 32'h80; reqReady = 1'b0;
    @(negedge clk);
    trapValid = 1'b0; redirectValid = 1'b0;
    #2;
    assertCount++; if (ifValid !== 1'b0) begin failCount++; $display("[TB] FAIL trap_if_valid: got %b, required 0", ifValid); end
    assertCount++; if (imemReqValid !== 1'b1) begin failCount++; $display("[TB] FAIL trap_req_valid: got %b, required 1", imemReqValid); end
    assertCount++; if (imemReqAddr !== 32'h100) begin failCount++; $display("[TB] FAIL trap_req_addr: got %h, required 100", imemReqAddr); end
  endtask

  task automatic test_wrap();
    bit found;
    @(negedge clk);
    redirectValid = 1'b1; redirectAddr = 32'hFFFF_FFFC;
    @(negedge clk);
    redirectValid = 1'b0;
    #2;
    assertCount++; if (imemReqAddr !== 32'hFFFF_FFFC) begin failCount++; $display("[TB] FAIL wrap_start_addr: got %h, required fffffffc", imemReqAddr); end
    reqReady = 1'b1; ifReady = 1'b1;
    sbq.push_back('{pc: 32'hFFFF_FFFC, instr: memData(32'hFFFF_FFFC)});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #2;
      if (ifValid && ifReady) found = 1'b1;
    end
    assertCount++;
    if (!found) begin failCount++; $display("[TB] FAIL wrap_accept: got no handshake, required handshake"); end
    @(negedge clk);
    reqReady = 1'b0; ifReady = 1'b0;
    #2;
    assertCount++; if (imemReqAddr !== 32'h0) begin failCount++; $display("[TB] FAIL wrap_next_addr: got %h, required 0", imemReqAddr); end
  endtask

  task automatic test_misalign();
    logic [31:0] expAddr;
`ifdef FETCH_MISALIGN_CHK_EN
    expAddr = 32'h100;
`else
    expAddr = 32'h200;
`endif
    @(negedge clk);
    redirectValid = 1'b1; redirectAddr = 32'h202;
`ifdef FETCH_MISALIGN_CHK_EN
    #2;
    assertCount++; if (misalignFault !== 1'b0) begin failCount++; $display("[TB] FAIL misalign_pre: got %b, required 0", misalignFault); end
`endif
    @(negedge clk);
    redirectValid = 1'b0;
    #2;
    assertCount++; if (imemReqAddr !== expAddr) begin failCount++; $display("[TB] FAIL misalign_addr: got %h, required %h", imemReqAddr, expAddr); end
`ifdef FETCH_MISALIGN_CHK_EN
    assertCount++; if (misalignFault !== 1'b1) begin failCount++; $display("[TB] FAIL misalign_pulse: got %b, required 1", misalignFault); end
    @(negedge clk);
    #2;
    assertCount++; if (misalignFault !== 1'b0) begin failCount++; $display("[TB] FAIL misalign_post: got %b, required 0", misalignFault); end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rspLatency = 2; reqReady = 1'b1; ifReady = 1'b1;
    redirectValid = 1'b1; redirectAddr = 32'h300;
    @(negedge clk);
    reqReady = 1'b0; redirectAddr = 32'h340;
    #2;
    assertCount++; if (imemReqValid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_drain_valid: got %b, required 0", imemReqValid); end
    @(negedge clk);
    redirectValid = 1'b0;
    #2;
    assertCount++; if (pcCurrent !== 32'h340) begin failCount++; $display("[TB] FAIL b2b_last_wins: got %h, required 340", pcCurrent); end
    @(negedge clk);
    #2;
    assertCount++; if (imemReqValid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_req_valid: got %b, required 1", imemReqValid); end
    assertCount++; if (imemReqAddr !== 32'h340) begin failCount++; $display("[TB] FAIL b2b_req_addr: got %h, required 340", imemReqAddr); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    rspLatency = 2; reqReady = 1'b1; ifReady = 1'b0;
    @(negedge clk);
    reqReady = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    assertCount++; if (imemReqValid !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_req_valid: got %b, required 1", imemReqValid); end
    assertCount++; if (imemReqAddr !== 32'h0) begin failCount++; $display("[TB] FAIL midrst_req_addr: got %h, required 0", imemReqAddr); end
    assertCount++; if (ifValid !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_if_valid: got %b, required 0", ifValid); end
  endtask

  initial begin : main
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_wait();
    test_trap_hold();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(negedge clk);
    assertCount++;
    if (sbq.size() != 0) begin failCount++; $display("[TB] FAIL sb_drained: got %0d pending, required 0", sbq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
